// File: rtl/aes_round_engine_if.sv
// Block-in / ciphertext-out handshake bundle for aes_round_engine.
interface aes_round_engine_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  // Producer/consumer side.
  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Engine side.
  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_round_engine.sv
// AES-128 encryption engine: iterates UNROLL rounds per clock with an
// on-the-fly key schedule. Optional abort input enabled by AES_ABORT_EN.
module aes_round_engine #(
  parameter int unsigned UNROLL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  aes_round_engine_if.slave bus,
  output logic              busy
`ifdef AES_ABORT_EN
  ,
  input  logic              abort
`endif
);

  localparam int unsigned DATA_W     = 128;
  localparam int unsigned RND_W      = 4;
  localparam int unsigned LAST_RND   = 10;
  localparam int unsigned LAST_START = LAST_RND + 1 - UNROLL;

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
    $error("aes_round_engine: UNROLL must be 1, 2, 5 or 10");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Byte 0 is the most significant byte of the 128-bit block.
  typedef logic [0:15][7:0] blk_t;
  typedef logic [0:3][31:0] col_t;

  state_e              r_fsm;
  state_e              w_fsm_next;
  logic [DATA_W-1:0]   r_state;
  logic [DATA_W-1:0]   r_key;
  logic [RND_W-1:0]    r_round;
  logic [DATA_W-1:0]   r_out_data;
  logic                w_accept;
  logic                w_finish;
  logic [DATA_W-1:0]   w_rnd_state;
  logic [DATA_W-1:0]   w_rnd_key;
  logic [RND_W-1:0]    w_rnd_num;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    inv  = gmul(x252, x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [RND_W-1:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] next_key(input logic [DATA_W-1:0] k,
                                                 input logic [RND_W-1:0] rnd);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^
         {rcon(rnd), 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // SubBytes and ShiftRows fused: row r of column c takes column (c+r)%4.
  function automatic logic [DATA_W-1:0] sub_shift(input logic [DATA_W-1:0] s);
    blk_t ib;
    blk_t ob;
    ib = s;
    ob = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        ob[r + 4*c] = sbox(ib[r + 4*((c + r) % 4)]);
      end
    end
    return ob;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [DATA_W-1:0] mix_cols(input logic [DATA_W-1:0] s);
    col_t ic;
    col_t oc;
    ic = s;
    for (int c = 0; c < 4; c++) begin
      oc[c] = mix_col(ic[c]);
    end
    return oc;
  endfunction

  // UNROLL chained rounds starting at r_round; the final round skips MixColumns.
  always_comb begin
    w_rnd_state = r_state;
    w_rnd_key   = r_key;
    w_rnd_num   = r_round;
    for (int unsigned u = 0; u < UNROLL; u++) begin
      w_rnd_num   = RND_W'(r_round + RND_W'(u));
      w_rnd_key   = next_key(w_rnd_key, w_rnd_num);
      w_rnd_state = sub_shift(w_rnd_state);
      if (w_rnd_num != RND_W'(LAST_RND)) w_rnd_state = mix_cols(w_rnd_state);
      w_rnd_state = w_rnd_state ^ w_rnd_key;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= IDLE;
    else        r_fsm <= w_fsm_next;
  end

  // Next-state and handshake decode; abort overrides accept and completion.
  always_comb begin
    w_fsm_next = r_fsm;
    w_accept   = 1'b0;
    w_finish   = 1'b0;
    case (r_fsm)
      IDLE: begin
        if (bus.in_valid) begin
          w_accept   = 1'b1;
          w_fsm_next = BUSY;
        end
      end
      BUSY: begin
        if (r_round == RND_W'(LAST_START)) begin
          w_finish   = 1'b1;
          w_fsm_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            w_accept   = 1'b1;
            w_fsm_next = BUSY;
          end else begin
            w_fsm_next = IDLE;
          end
        end
      end
      default: w_fsm_next = IDLE;
    endcase
`ifdef AES_ABORT_EN
    if (abort && (r_fsm != IDLE)) begin
      w_accept   = 1'b0;
      w_finish   = 1'b0;
      w_fsm_next = IDLE;
    end
`endif
  end

  // Datapath: load on accept, iterate while busy, capture the result on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= '0;
      r_key      <= '0;
      r_round    <= '0;
      r_out_data <= '0;
    end else begin
      if (w_accept) begin
        r_state <= bus.in_data ^ bus.in_key;
        r_key   <= bus.in_key;
        r_round <= RND_W'(1);
      end else if (r_fsm == BUSY) begin
        r_state <= w_rnd_state;
        r_key   <= w_rnd_key;
        r_round <= RND_W'(r_round + RND_W'(UNROLL));
      end
      if (w_finish) r_out_data <= w_rnd_state;
    end
  end

  assign bus.in_ready  = (r_fsm == IDLE) || ((r_fsm == DONE) && bus.out_ready);
  assign bus.out_valid = (r_fsm == DONE);
  assign bus.out_data  = r_out_data;
  assign busy          = (r_fsm == BUSY);

endmodule

// File: doc/aes_round_engine.md
AES_ROUND_ENGINE -- requirements
Module: aes_round_engine

Interface
REQ-001 The block SHALL have parameter UNROLL, default 1, meaning AES-128 rounds computed per clock; legal values are 1, 2, 5 and 10.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: plaintext and key on in_data and in_key are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the engine can accept a block this cycle.
REQ-006 The block SHALL have port in_data, input, 128 bits: plaintext block.
REQ-007 The block SHALL have port in_key, input, 128 bits: cipher key.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data holds a finished ciphertext.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes out_data this cycle.
REQ-010 The block SHALL have port out_data, output, 128 bits: ciphertext.
REQ-011 The block SHALL have port busy, output, 1 bit: a block is in flight (state BUSY).

Function
REQ-012 States SHALL be IDLE, BUSY and DONE; in_ready SHALL equal (state==IDLE) or (state==DONE and out_ready); out_valid SHALL equal (state==DONE).
REQ-013 Accept SHALL occur on an edge where in_valid and in_ready are both 1: state register <= in_data XOR in_key, round key register <= in_key, round counter <= 1, state <= BUSY.
REQ-014 In BUSY, each edge SHALL apply UNROLL consecutive rounds r..r+UNROLL-1 (SubBytes, ShiftRows, MixColumns, AddRoundKey), with the key schedule advanced once per round and Rcon derived from the round number.
REQ-015 Round 10 SHALL omit MixColumns.
REQ-016 The counter SHALL advance by UNROLL per edge; on the edge completing round 10, the result SHALL load into out_data and state SHALL become DONE.
REQ-017 Latency SHALL be 10/UNROLL edges from the accept edge to the edge asserting out_valid (10, 5, 2 or 1).
REQ-018 out_data SHALL be held stable while out_valid is 1 and out_ready is 0.
REQ-019 In DONE with out_ready=1 and in_valid=0, state SHALL return to IDLE and out_data SHALL retain its value.
REQ-020 In DONE with out_ready=1 and in_valid=1, the new block SHALL be accepted on the same edge (back-to-back) with no IDLE cycle.
REQ-021 in_valid SHALL be ignored while BUSY; inputs are sampled only on accept.
REQ-022 An UNROLL value outside {1,2,5,10} SHALL stop elaboration with an error.

Reset
REQ-023 With rst_n low, the block SHALL asynchronously enter IDLE: out_valid=0, busy=0, in_ready=1, out_data=0, and the state, key and counter registers cleared.
REQ-024 Reset asserted during BUSY or DONE SHALL discard the in-flight block; no out_valid SHALL follow the deassertion of reset.

Configuration
REQ-025 Macro AES_ABORT_EN defined SHALL add port abort, input, 1 bit; abort=1 on an edge in BUSY or DONE SHALL force IDLE with out_valid=0, and abort SHALL take priority over accept and completion on the same edge.
REQ-026 Without AES_ABORT_EN, port abort SHALL be absent and the behaviour SHALL be as REQ-012 to REQ-024.

Verification
REQ-027 UNROLL=1, key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a and out_valid rising 10 edges after accept.
REQ-028 The same vector at UNROLL=2, 5 and 10 -> identical ciphertext after 5, 2 and 1 edges respectively.
REQ-029 UNROLL=1, key 2b7e151628aed2a6abf7158809cf4f3c, data 3243f6a8885a308d313198a2e0370734, out_ready held 0 for 5 cycles after out_valid -> out_data stays 3925841d02dc09fbdc118597196a0b32 and in_ready stays 0.
REQ-030 Two blocks presented back-to-back with out_ready=1 -> the second is accepted on the edge the first completes handshake; both ciphertexts are correct.
REQ-031 rst_n pulsed low at round 4 -> out_valid=0 and out_data=0 immediately; the next accepted block produces the correct ciphertext.
REQ-032 AES_ABORT_EN defined, abort at round 6 -> IDLE on the next edge; no out_valid; in_ready=1.
